// File: rtl/mac_dot_seq.sv
// mac_dot_seq: runs one signed mac_Nbits instance through a dot product of a runtime length with valid/ready I/O.
// Define MAC_DOT_SEQ_OVF_EN to build a wide shadow accumulator that drives res_ovf.
module mac_dot_seq #(
    parameter int N = 8,
    parameter int MAX_LEN = 16,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   in_w,
    input  logic signed [N-1:0]   in_x,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic signed [2*N-1:0] res_data,
    output logic                  res_ovf
);
    localparam logic [1:0] S_IDLE = 2'd0, S_CLEAR = 2'd1, S_ACCUM = 2'd2, S_DONE = 2'd3;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    logic [1:0] state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic clr, fire;
    logic signed [2*N-1:0] acc;

    assign clr       = state_q == S_CLEAR;
    assign in_ready  = state_q == S_ACCUM;
    assign res_valid = state_q == S_DONE;
    assign busy      = state_q != S_IDLE;
    assign fire      = in_valid & in_ready;
    // Only expose the sum once it is final, so partial sums never leak out.
    assign res_data  = res_valid ? acc : '0;

    mac_Nbits #(.N(N)) u_mac (
        .clk (clk),
        .rst (rst | clr),
        .en  (fire),
        .w   (in_w),
        .x   (in_x),
        .acc (acc)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_CLEAR;
                len_d   = (len > MAX_L) ? MAX_L : len;
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = (len_q == '0) ? S_DONE : S_ACCUM;
            end
            S_ACCUM: if (fire) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_d == len_q) ? S_DONE : S_ACCUM;
            end
            default: state_d = res_ready ? S_IDLE : S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MAC_DOT_SEQ_OVF_EN
    localparam int SW = 2 * N + LEN_W;
    logic signed [SW-1:0] sh_q;
    logic signed [2*N-1:0] prod;
    logic [LEN_W:0] top;

    assign prod = in_w * in_x;
    // In range exactly when every bit above the 2N-bit sign position matches it.
    assign top     = sh_q[SW-1:2*N-1];
    assign res_ovf = res_valid && !((&top) || (~|top));

    always_ff @(posedge clk) begin
        if (rst || clr) sh_q <= '0;
        else if (fire) sh_q <= sh_q + {{LEN_W{prod[2*N-1]}}, prod};
    end
`else
    assign res_ovf = 1'b0;
`endif
endmodule

module mac_Nbits #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic signed [N-1:0]   w,
    input  logic signed [N-1:0]   x,
    output logic signed [2*N-1:0] acc
);
    logic signed [2*N-1:0] acc_q;

    assign acc = acc_q;

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else if (en) acc_q <= acc_q + w * x;
    end
endmodule
